// File: rtl/mfx_pkg.sv
// Shared definitions for the mfx_alu execute-stage ALU: opcodes, multiplier
// state encoding, flag bit positions and flag write masks.
package mfx_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADC   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_SBC   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_SWAP  = 4'd7;
    localparam logic [3:0] OP_ASR   = 4'd8;
    localparam logic [3:0] OP_LSR   = 4'd9;
    localparam logic [3:0] OP_ROR   = 4'd10;
    localparam logic [3:0] OP_PASSB = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;
    localparam logic [3:0] OP_MULS  = 4'd13;
    localparam logic [3:0] OP_MULSU = 4'd14;
    localparam logic [3:0] OP_RSVD  = 4'd15;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMult = 2'd1,
        StSign = 2'd2
    } mul_state_e;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

    localparam logic [3:0] WR_ARITH = 4'b1111;
    localparam logic [3:0] WR_LOGIC = 4'b1110;
    localparam logic [3:0] WR_MUL   = 4'b0011;
    localparam logic [3:0] WR_NONE  = 4'b0000;

endpackage

// File: rtl/mfx_mul_seq.sv
// Iterative shift-add multiplier: latch operand magnitudes, accumulate one
// multiplier bit per cycle, then apply the sign fix in a final cycle.
module mfx_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 a_signed,
    input  logic                 b_signed,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 fin,
    output logic [2*WIDTH-1:0]   prod
);
    import mfx_pkg::*;

    localparam int unsigned CW = $clog2(WIDTH + 1);

    mul_state_e          state_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic [2*WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]    mplier_q;
    logic [CW-1:0]       cnt_q;
    logic                neg_q;

    logic                sa, sb;
    logic [WIDTH-1:0]    mag_a, mag_b;

    always_comb begin
        sa    = a_signed & a[WIDTH-1];
        sb    = b_signed & b[WIDTH-1];
        mag_a = sa ? ('0 - a) : a;
        mag_b = sb ? ('0 - b) : b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                        mplier_q <= mag_b;
                        cnt_q    <= '0;
                        neg_q    <= sa ^ sb;
                        state_q  <= StMult;
                    end
                end
                StMult: begin
                    if (flush) begin
                        state_q <= StIdle;
                    end else begin
                        if (mplier_q[0]) begin
                            acc_q <= acc_q + mcand_q;
                        end
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= StSign;
                        end
                    end
                end
                StSign:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Sign fix is applied combinationally while in StSign; the top registers it.
    always_comb begin
        busy = (state_q != StIdle);
        fin  = (state_q == StSign) && !flush;
        prod = neg_q ? ('0 - acc_q) : acc_q;
    end

endmodule

// File: rtl/mfx_alu.sv
// Execute-stage ALU: single-cycle arithmetic/logic/shift datapath with
// registered results, plus the sequential multiplier and output mux.
module mfx_alu #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [OPW-1:0]    Op,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              C_in,
    input  logic              Z_in,
    input  logic              Flush,
    output logic              Busy,
    output logic              Done,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  Q_H,
    output logic [3:0]        Flags,
    output logic [3:0]        Flags_Wr
);
    import mfx_pkg::*;

    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned HW  = WIDTH / 2;

    logic [3:0]          op4;
    logic [WIDTH:0]      sum_w, dif_w;
    logic [WIDTH-1:0]    res;
    logic [3:0]          fl, wr, mul_fl;
    logic                is_mul, alu_go, mul_go;
    logic                mul_busy, mul_fin;
    logic [2*WIDTH-1:0]  prod;

    assign op4 = 4'(Op);

    always_comb begin
        res    = B;
        fl     = '0;
        wr     = WR_NONE;
        is_mul = 1'b0;
        sum_w  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, (op4 == OP_ADC) & C_in};
        dif_w  = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, (op4 == OP_SBC) & C_in};
        case (op4)
            OP_ADD, OP_ADC: begin
                res        = sum_w[WIDTH-1:0];
                fl[FLAG_C] = sum_w[WIDTH];
                fl[FLAG_V] = (A[MSB] == B[MSB]) && (res[MSB] != A[MSB]);
                wr         = WR_ARITH;
            end
            OP_SUB, OP_SBC: begin
                res        = dif_w[WIDTH-1:0];
                fl[FLAG_C] = dif_w[WIDTH];
                fl[FLAG_V] = (A[MSB] != B[MSB]) && (res[MSB] != A[MSB]);
                wr         = WR_ARITH;
            end
            OP_AND: begin res = A & B; wr = WR_LOGIC; end
            OP_OR:  begin res = A | B; wr = WR_LOGIC; end
            OP_XOR: begin res = A ^ B; wr = WR_LOGIC; end
            OP_SWAP: res = {A[HW-1:0], A[WIDTH-1:HW]};
            OP_ASR, OP_LSR, OP_ROR: begin
                if (op4 == OP_ASR) begin
                    res = {A[MSB], A[WIDTH-1:1]};
                end else if (op4 == OP_LSR) begin
                    res = {1'b0, A[WIDTH-1:1]};
                end else begin
                    res = {C_in, A[WIDTH-1:1]};
                end
                fl[FLAG_C] = A[0];
                fl[FLAG_V] = res[MSB] ^ A[0];
                wr         = WR_ARITH;
            end
            OP_MUL, OP_MULS, OP_MULSU: is_mul = 1'b1;
            default: res = B;
        endcase
        fl[FLAG_N] = res[MSB];
        fl[FLAG_Z] = (op4 == OP_SBC) ? (Z_in & (res == '0)) : (res == '0);
    end

    always_comb begin
        alu_go = Start && !mul_busy && !is_mul;
        mul_go = Start && !mul_busy && is_mul;
        mul_fl = '0;
        mul_fl[FLAG_C] = prod[2*WIDTH-1];
        mul_fl[FLAG_Z] = (prod == '0);
    end

    mfx_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .start    (mul_go),
        .a_signed ((op4 == OP_MULS) || (op4 == OP_MULSU)),
        .b_signed (op4 == OP_MULS),
        .flush    (Flush),
        .a        (A),
        .b        (B),
        .busy     (mul_busy),
        .fin      (mul_fin),
        .prod     (prod)
    );

    assign Busy = mul_busy;

    // Unwritten flag bits are reported as 0; Flags_Wr is only non-zero with Done.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Done     <= 1'b0;
            Q        <= '0;
            Q_H      <= '0;
            Flags    <= '0;
            Flags_Wr <= '0;
        end else begin
            Done     <= 1'b0;
            Flags_Wr <= '0;
            if (mul_fin) begin
                Q        <= prod[WIDTH-1:0];
                Q_H      <= prod[2*WIDTH-1:WIDTH];
                Flags    <= mul_fl;
                Flags_Wr <= WR_MUL;
                Done     <= 1'b1;
            end else if (alu_go) begin
                Q        <= res;
                Q_H      <= '0;
                Flags    <= fl & wr;
                Flags_Wr <= wr;
                Done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mfx_alu.sv
// Directed self-checking bench for mfx_alu at WIDTH=8 and WIDTH=16.
module tb_mfx_alu;
    import mfx_pkg::*;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst8, start8, cin8, zin8, flush8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  q8, qh8;
    logic [3:0]  flags8, fwr8;

    logic        rst16, start16, cin16, zin16, flush16;
    logic [3:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [15:0] q16, qh16;
    logic [3:0]  flags16, fwr16;

    int errors = 0;
    int checks = 0;

    mfx_alu #(.WIDTH(8), .OPW(4)) u8 (
        .Clk(Clk), .Reset_n(rst8), .Start(start8), .Op(op8), .A(a8), .B(b8),
        .C_in(cin8), .Z_in(zin8), .Flush(flush8), .Busy(busy8), .Done(done8),
        .Q(q8), .Q_H(qh8), .Flags(flags8), .Flags_Wr(fwr8)
    );

    mfx_alu #(.WIDTH(16), .OPW(4)) u16 (
        .Clk(Clk), .Reset_n(rst16), .Start(start16), .Op(op16), .A(a16), .B(b16),
        .C_in(cin16), .Z_in(zin16), .Flush(flush16), .Busy(busy16), .Done(done16),
        .Q(q16), .Q_H(qh16), .Flags(flags16), .Flags_Wr(fwr16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic alu_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic cin, input logic zin,
                          input logic [7:0] eq, input logic [3:0] ef, input logic [3:0] ewr);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b; cin8 = cin; zin8 = zin;
        tick();
        start8 = 1'b0;
        check({tag, "_done"},  64'(done8),  64'd1);
        check({tag, "_q"},     64'(q8),     64'(eq));
        check({tag, "_qh"},    64'(qh8),    64'd0);
        check({tag, "_flags"}, 64'(flags8), 64'(ef));
        check({tag, "_wr"},    64'(fwr8),   64'(ewr));
    endtask

    task automatic run_mul8(input string tag, input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [15:0] ep, input logic [3:0] ef);
        int c;
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        tick();
        start8 = 1'b0;
        c = 1;
        while (!done8 && c < 40) begin
            tick();
            c++;
        end
        check({tag, "_latency"}, 64'(c),            64'd10);
        check({tag, "_prod"},    64'({qh8, q8}),    64'(ep));
        check({tag, "_flags"},   64'(flags8),       64'(ef));
        check({tag, "_wr"},      64'(fwr8),         64'(WR_MUL));
        check({tag, "_busy"},    64'(busy8),        64'd0);
    endtask

    initial begin
        int c;
        int busy_cnt;
        int dones;

        rst8 = 1'b0; start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        cin8 = 1'b0; zin8 = 1'b0; flush8 = 1'b0;
        rst16 = 1'b0; start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        cin16 = 1'b0; zin16 = 1'b0; flush16 = 1'b0;
        #12;
        check("rst_busy",  64'(busy8),  64'd0);
        check("rst_done",  64'(done8),  64'd0);
        check("rst_q",     64'(q8),     64'd0);
        check("rst_qh",    64'(qh8),    64'd0);
        check("rst_flags", 64'(flags8), 64'd0);
        check("rst_wr",    64'(fwr8),   64'd0);
        rst8 = 1'b1; rst16 = 1'b1;
        tick();

        alu_op("add_ff_01", OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b0011, 4'b1111);
        tick();
        check("add_done_drop", 64'(done8),  64'd0);
        check("add_wr_drop",   64'(fwr8),   64'd0);
        check("add_q_hold",    64'(q8),     64'h00);
        check("add_fl_hold",   64'(flags8), 64'b0011);

        alu_op("sbc_z0",   OP_SBC,   8'h05, 8'h05, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b1111);
        alu_op("sbc_z1",   OP_SBC,   8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 4'b0010, 4'b1111);
        alu_op("sbc_brw",  OP_SBC,   8'h10, 8'h20, 1'b1, 1'b1, 8'hEF, 4'b0101, 4'b1111);
        alu_op("sub_brw",  OP_SUB,   8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 4'b0101, 4'b1111);
        alu_op("add_ovf",  OP_ADD,   8'h7F, 8'h01, 1'b1, 1'b0, 8'h80, 4'b1100, 4'b1111);
        alu_op("adc_c",    OP_ADC,   8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 4'b0000, 4'b1111);
        alu_op("and",      OP_AND,   8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 4'b0000, 4'b1110);
        alu_op("or",       OP_OR,    8'h80, 8'h01, 1'b0, 1'b0, 8'h81, 4'b0100, 4'b1110);
        alu_op("xor",      OP_XOR,   8'hAA, 8'hAA, 1'b0, 1'b0, 8'h00, 4'b0010, 4'b1110);
        alu_op("swap",     OP_SWAP,  8'hA5, 8'h00, 1'b0, 1'b0, 8'h5A, 4'b0000, 4'b0000);
        alu_op("asr",      OP_ASR,   8'h81, 8'h00, 1'b0, 1'b0, 8'hC0, 4'b0101, 4'b1111);
        alu_op("lsr",      OP_LSR,   8'h81, 8'h00, 1'b1, 1'b0, 8'h40, 4'b1001, 4'b1111);
        alu_op("ror",      OP_ROR,   8'h02, 8'h00, 1'b1, 1'b0, 8'h81, 4'b1100, 4'b1111);
        alu_op("passb",    OP_PASSB, 8'h11, 8'h3C, 1'b0, 1'b0, 8'h3C, 4'b0000, 4'b0000);
        alu_op("rsvd",     OP_RSVD,  8'h11, 8'h77, 1'b0, 1'b0, 8'h77, 4'b0000, 4'b0000);

        // MUL 0xFF x 0xFF with Start pulses during cycles 3..5 that must be ignored
        start8 = 1'b1; op8 = OP_MUL; a8 = 8'hFF; b8 = 8'hFF;
        tick();
        c = 1;
        busy_cnt = 0;
        while (!done8 && c < 40) begin
            if (busy8) busy_cnt++;
            if (c == 6) check("mul_q_hold", 64'(q8), 64'h77);
            start8 = (c >= 3 && c <= 5);
            op8 = OP_ADD; a8 = 8'h11; b8 = 8'h22;
            tick();
            c++;
        end
        check("mul_latency",  64'(c),           64'd10);
        check("mul_busy_cyc", 64'(busy_cnt),    64'd9);
        check("mul_busy_end", 64'(busy8),       64'd0);
        check("mul_prod",     64'({qh8, q8}),   64'hFE01);
        check("mul_flags",    64'(flags8),      64'b0001);
        check("mul_wr",       64'(fwr8),        64'b0011);
        alu_op("b2b_add", OP_ADD, 8'h02, 8'h03, 1'b0, 1'b0, 8'h05, 4'b0000, 4'b1111);

        run_mul8("muls",   OP_MULS,  8'h80, 8'h7F, 16'hC080, 4'b0001);
        run_mul8("mulsu",  OP_MULSU, 8'hFF, 8'h02, 16'hFFFE, 4'b0001);
        run_mul8("mul0",   OP_MUL,   8'h00, 8'h37, 16'h0000, 4'b0010);
        run_mul8("muls_nn", OP_MULS, 8'hFF, 8'hFF, 16'h0001, 4'b0000);

        // Flush in cycle 4 of a MUL
        start8 = 1'b1; op8 = OP_MUL; a8 = 8'h0F; b8 = 8'h0F;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        flush8 = 1'b1;
        tick();
        flush8 = 1'b0;
        check("flush_busy", 64'(busy8),  64'd0);
        check("flush_done", 64'(done8),  64'd0);
        check("flush_q",    64'(q8),     64'h01);
        check("flush_qh",   64'(qh8),    64'h00);
        alu_op("post_flush_add", OP_ADD, 8'h07, 8'h08, 1'b0, 1'b0, 8'h0F, 4'b0000, 4'b1111);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) dones++;
        end
        check("flush_no_done", 64'(dones), 64'd0);

        // Flush in IDLE alongside Start: Start still accepted
        flush8 = 1'b1;
        alu_op("flush_idle_add", OP_ADD, 8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 4'b1100, 4'b1111);
        flush8 = 1'b0;

        // Asynchronous reset in cycle 3 of a MULS
        start8 = 1'b1; op8 = OP_MULS; a8 = 8'h80; b8 = 8'h7F;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        #2 rst8 = 1'b0;
        #1;
        check("arst_busy",  64'(busy8),  64'd0);
        check("arst_done",  64'(done8),  64'd0);
        check("arst_q",     64'(q8),     64'd0);
        check("arst_qh",    64'(qh8),    64'd0);
        check("arst_flags", 64'(flags8), 64'd0);
        check("arst_wr",    64'(fwr8),   64'd0);
        rst8 = 1'b1;
        dones = 0;
        busy_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done8) dones++;
            if (busy8) busy_cnt++;
        end
        check("arst_no_done", 64'(dones),    64'd0);
        check("arst_no_busy", 64'(busy_cnt), 64'd0);

        // WIDTH=16 MUL 0xFFFF x 0xFFFF
        start16 = 1'b1; op16 = OP_MUL; a16 = 16'hFFFF; b16 = 16'hFFFF;
        tick();
        start16 = 1'b0;
        c = 1;
        while (!done16 && c < 60) begin
            tick();
            c++;
        end
        check("mul16_latency", 64'(c),             64'd18);
        check("mul16_prod",    64'({qh16, q16}),   64'hFFFE0001);
        check("mul16_flags",   64'(flags16),       64'b0001);
        check("mul16_wr",      64'(fwr16),         64'b0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mfx_alu.md
# mfx_alu

Parametrised successor to the 8-bit single-cycle core ALU. It registers arithmetic/logic/shift results for any even operand width and adds an iterative shift-add multiplier (unsigned, signed, signed×unsigned) with a start/done handshake. It sits in the execute stage between the register file read ports and the write-back/SREG update logic. The core's decoder drives a pre-decoded opcode; this block does no instruction-word decoding.

## Interface
- WIDTH, 8: operand width; even, ≥4.
- OPW, 4: opcode width.

- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  launch operation; accepted only when Busy=0.
- Op  in  OPW  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 SWAP, 8 ASR, 9 LSR, 10 ROR, 11 PASSB, 12 MUL, 13 MULS, 14 MULSU, 15 reserved (treated as PASSB).
- A, B  in  WIDTH  operands, sampled on the accepted Start edge.
- C_in, Z_in  in  1  current SREG C and Z, sampled with Start.
- Flush  in  1  abort in-flight multiply (branch skip/kill).
- Busy  out  1  multiply in progress.
- Done  out  1  one-cycle pulse, result valid.
- Q  out  WIDTH  result, or product low half.
- Q_H  out  WIDTH  product high half; 0 for non-multiply ops.
- Flags  out  4  {V,N,Z,C}.
- Flags_Wr  out  4  per-flag write mask, valid with Done.

## Operation
- States: IDLE, MULT, SIGN. Reset → IDLE; Busy, Done, Q, Q_H, Flags, Flags_Wr all 0.
- IDLE + Start + non-multiply op: compute, register Q/Flags/Flags_Wr, pulse Done next cycle; stay IDLE.
- IDLE + Start + MUL/MULS/MULSU: latch magnitudes |A|, |B| (sign per variant; MULSU treats B as unsigned), latch negate = sign(A) XOR sign(B); go MULT, Busy=1.
- MULT: one multiplier bit per cycle, LSB first, 2·WIDTH accumulator; after WIDTH iterations go SIGN.
- SIGN: two's-complement-negate product if negate; register {Q_H,Q}; pulse Done; go IDLE, Busy=0.
- Start while Busy=1: ignored, no effect on state or outputs.
- Flush while Busy: go IDLE next edge, no Done, Q/Q_H/Flags retain previous values. Flush in IDLE: no effect; a Start in the same cycle as Flush in IDLE is still accepted.
- Arithmetic: ADD/ADC = A+B+(ADC&C_in); SUB/SBC = A−B−(SBC&C_in); C = carry out / borrow; V = signed overflow; N = Q[WIDTH−1]; Z = (Q==0), except SBC: Z = Z_in & (Q==0).
- Logic AND/OR/XOR: V=0; N, Z updated; C not written.
- SWAP: exchange WIDTH/2 halves; no flags written. PASSB: Q=B; no flags written.
- Shifts: Q = A>>1 with MSB = A[MSB] (ASR), 0 (LSR), C_in (ROR); C = A[0]; N = Q MSB; Z; V = N XOR C.
- Multiply: C = product bit 2·WIDTH−1; Z = (product==0); N, V not written.
- Flags_Wr: arith/shift 1111; logic 1110; multiply 0011; SWAP/PASSB 0000. Done=0 ⇒ Flags_Wr=0.

## Timing
- Non-multiply: Start sampled at edge 0 → Done=1 during cycle 1, latency 1.
- Multiply: Start at edge 0 → Busy=1 cycles 1..WIDTH+1, Done=1 cycle WIDTH+2 (Busy=0 that cycle); fixed latency WIDTH+2 for all three variants.
- Back-to-back: a new Start is accepted in the same cycle Done is high.
- Q/Q_H/Flags hold until the next Done. Reset asserted mid-multiply forces IDLE immediately; no Done after release.

## Structure
- Shared package mfx_pkg: opcode localparams, state encoding, flag bit indices (FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3).
- One sub-module: mfx_mul_seq (magnitude/iterate/sign-fix datapath with its FSM); top module holds the single-cycle datapath and output mux.

## Test plan
- WIDTH=8, ADD A=0xFF B=0x01 → Q=0x00, Flags {V,N,Z,C}=0011, Done at cycle 1.
- SBC A=0x05 B=0x05 C_in=0 Z_in=0 → Q=0x00, Z=0, C=0; repeat with Z_in=1 → Z=1.
- MUL 0xFF×0xFF → {Q_H,Q}=0xFE01, C=1, Z=0, Flags_Wr=0011, Done at cycle 10; Start pulses at cycles 3–5 ignored.
- MULS 0x80×0x7F → 0xC080, C=1; MULSU 0xFF×0x02 → 0xFFFE.
- Flush at cycle 4 of a MUL → no Done, Busy=0 at cycle 5, outputs unchanged; ADD started at cycle 5 → Done at cycle 6.
- Reset_n low at cycle 3 of MULS → all outputs 0 asynchronously; no Done after release; WIDTH=16 MUL 0xFFFF×0xFFFF → 0xFFFE0001 at cycle 18.
